flash_byte_reader: RTL

Byte-stream fetch engine that sits directly upstream of the flash read port. On a start command it walks a byte range of flash and issues 32-bit word reads on the flash address bus. It captures the returned words and unpacks them into a byte stream for the downstream consumer, under a valid/ready handshake. Byte addressing, unaligned starts and arbitrary lengths are handled here, so consumers never see word boundaries.

---
 rtl/flash_byte_reader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_byte_reader.sv
// flash_byte_reader: walks a byte range of a 32-bit-word flash and streams it out as bytes.
// Optional build macro FLASH_BYTE_READER_PREFETCH_EN adds a second word buffer that overlaps reads with unpacking.
// Handshake: a byte moves on any rising edge with out_valid && out_ready; once out_valid rises, it and out_byte hold until that edge.
module flash_byte_reader #(
    parameter int READ_LATENCY = 1,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [24:0]      start_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [22:0]      flash_addr,
    input  logic [31:0]      flash_q,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(READ_LATENCY + 2);
    localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] UNPACK = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       lane;
    logic [31:0]      word_buf;
    logic             handshake;
    logic             last_byte;
    logic             last_lane;

    assign handshake = out_valid && out_ready;
    assign last_byte = (remaining == LEN_ONE);
    assign last_lane = (lane == 2'd3);

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

`ifdef FLASH_BYTE_READER_PREFETCH_EN
    // One read is outstanding at most; its result lands either straight in word_buf
    // (when the FSM is waiting for it) or in nxt_buf until the current word drains.
    logic             rd_busy;
    logic [CNT_W-1:0] rd_cnt;
    logic [31:0]      nxt_buf;
    logic             nxt_valid;
    logic             rd_hit;
    logic             avail;
    logic [31:0]      avail_word;
    logic [LEN_W-1:0] left_in_word;
    logic             pf_first;
    logic             pf_next;

    assign rd_hit       = rd_busy && (rd_cnt == CAP_CNT);
    assign avail        = nxt_valid || rd_hit;
    assign avail_word   = nxt_valid ? nxt_buf : flash_q;
    assign left_in_word = LEN_W'(3'd4 - {1'b0, lane});
    // Prefetch only when bytes are still owed beyond the word about to be unpacked.
    assign pf_first     = (remaining > left_in_word);
    assign pf_next      = (remaining > LEN_W'(5));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_addr <= '0;
            out_byte   <= '0;
            out_valid  <= 1'b0;
            remaining  <= '0;
            lane       <= '0;
            word_buf   <= '0;
            nxt_buf    <= '0;
            nxt_valid  <= 1'b0;
            rd_busy    <= 1'b0;
            rd_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (rd_busy) begin
                if (rd_hit) begin
                    rd_busy   <= 1'b0;
                    nxt_buf   <= flash_q;
                    nxt_valid <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + CNT_ONE;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        lane      <= start_addr[1:0];
                        remaining <= length;
                        if (length == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            flash_addr <= start_addr[24:2];
                            rd_busy    <= 1'b1;
                            rd_cnt     <= '0;
                            busy       <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (avail) begin
                        word_buf  <= avail_word;
                        out_byte  <= lane_byte(avail_word, lane);
                        out_valid <= 1'b1;
                        nxt_valid <= 1'b0;
                        state     <= UNPACK;
                        if (pf_first) begin
                            flash_addr <= flash_addr + 23'd1;
                            rd_busy    <= 1'b1;
                            rd_cnt     <= '0;
                        end
                    end
                end
                UNPACK: begin
                    if (handshake) begin
                        remaining <= remaining - LEN_ONE;
                        lane      <= lane + 2'd1;
                        if (last_byte) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (last_lane) begin
                            if (avail) begin
                                word_buf  <= avail_word;
                                out_byte  <= lane_byte(avail_word, 2'd0);
                                nxt_valid <= 1'b0;
                                if (pf_next) begin
                                    flash_addr <= flash_addr + 23'd1;
                                    rd_busy    <= 1'b1;
                                    rd_cnt     <= '0;
                                end
                            end else begin
                                out_valid <= 1'b0;
                                state     <= FETCH;
                            end
                        end else begin
                            out_byte <= lane_byte(word_buf, lane + 2'd1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    logic [CNT_W-1:0] fetch_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_addr <= '0;
            out_byte   <= '0;
            out_valid  <= 1'b0;
            remaining  <= '0;
            lane       <= '0;
            word_buf   <= '0;
            fetch_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lane      <= start_addr[1:0];
                        remaining <= length;
                        if (length == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            flash_addr <= start_addr[24:2];
                            fetch_cnt  <= '0;
                            busy       <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // The flash samples flash_addr one edge after it moves, then needs READ_LATENCY more.
                    if (fetch_cnt == CAP_CNT) begin
                        word_buf  <= flash_q;
                        out_byte  <= lane_byte(flash_q, lane);
                        out_valid <= 1'b1;
                        state     <= UNPACK;
                    end else begin
                        fetch_cnt <= fetch_cnt + CNT_ONE;
                    end
                end
                UNPACK: begin
                    if (handshake) begin
                        remaining <= remaining - LEN_ONE;
                        lane      <= lane + 2'd1;
                        if (last_byte) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (last_lane) begin
                            out_valid  <= 1'b0;
                            flash_addr <= flash_addr + 23'd1;
                            fetch_cnt  <= '0;
                            state      <= FETCH;
                        end else begin
                            out_byte <= lane_byte(word_buf, lane + 2'd1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule
